// File: rtl/mfc_pkg.sv
// rtl/mfc_pkg.sv - shared types, constants and reference compare for the comparator vector sequencer
//
// Contents:
//   OP_W        operand width of both comparators
//   mfc_state_t sequencer FSM states
//   mfc_res_t   packed comparator result {eq, ae, gt, d[3:0]}
//   CORNER_TAB  fixed {a, b} pairs used by the corner-vector build option
//   mfc_expect  golden comparator result for an operand pair

package mfc_pkg;

   localparam int OP_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } mfc_state_t;

   typedef struct packed {
      logic       eq;
      logic       ae;
      logic       gt;
      logic [3:0] d;
   } mfc_res_t;

   // Each entry is {a, b}; entry i is applied at the i-th LOAD of a run.
   localparam logic [0:3][2*OP_W-1:0] CORNER_TAB = '{
      32'h0000_0000,
      32'hFFFF_0000,
      32'h8000_7FFF,
      32'h53DB_D3DB
   };

   // Unsigned compare; d is the highest differing bit, 0 when the operands match.
   function automatic mfc_res_t mfc_expect(input logic [OP_W-1:0] op_a,
                                           input logic [OP_W-1:0] op_b);
      mfc_res_t        r;
      logic [OP_W-1:0] diff;
      diff = op_a ^ op_b;
      r.eq = (op_a == op_b);
      r.ae = (op_a >= op_b);
      r.gt = (op_a > op_b);
      r.d  = 4'd0;
      for (int i = 0; i < OP_W; i++) begin
         if (diff[i]) begin
            r.d = 4'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mfc_lfsr32.sv
// rtl/mfc_lfsr32.sv - 32-bit Galois LFSR operand generator
//
// Parameters:
//   RST_VAL  value forced by reset (must be non-zero)
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   load   in   load seed (has priority over step)
//   step   in   advance one step
//   seed   in   32  load value
//   value  out  32  current LFSR state

module mfc_lfsr32 #(
   parameter logic [31:0] RST_VAL = 32'hACE1_531E
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] seed,
   output logic [31:0] value
);

   localparam logic [31:0] TAPS = 32'h8020_0003;

   // Right-shifting Galois form: the bit shifted out of bit 0 folds back
   // through TAPS. Bit 31 of TAPS is set, so the step is invertible and a
   // non-zero state can never fall to zero; a zero seed is replaced on load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= RST_VAL;
      end else if (load) begin
         value <= (seed == 32'd0) ? 32'd1 : seed;
      end else if (step) begin
         value <= {1'b0, value[31:1]} ^ (value[0] ? TAPS : 32'd0);
      end
   end

endmodule

// File: rtl/mfc_vec_seq.sv
// rtl/mfc_vec_seq.sv - vector sequencer that drives and cross-checks two 16-bit magnitude comparators
//
// Build option: MFC_SEQ_CORNER_EN - first four vectors of each run come from CORNER_TAB.
// Parameters:
//   N_VEC     vectors per run (1..65535)
//   SEED      LFSR seed half; LFSR loads {SEED, ~SEED}
//   WAIT_CYC  comparator settle cycles per vector (1..15)
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               run request, honoured in IDLE/DONE only
//   a, b                16-bit operands driven to both comparators
//   eq1, ae1, gt1, d1   comparator 1 result (equal, a>=b, a>b, top differing bit)
//   eq2, ae2, gt2, d2   comparator 2 result, same meanings
//   busy                run in progress (LOAD/SETTLE/CHECK)
//   done                run complete, held until next start
//   vec_cnt             vectors checked this run
//   err_cnt             failing vectors, saturating
//   err_flag            sticky: at least one failing vector this run

module mfc_vec_seq
   import mfc_pkg::*;
#(
   parameter int          N_VEC    = 256,
   parameter logic [15:0] SEED     = 16'hACE1,
   parameter int          WAIT_CYC = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [OP_W-1:0] a,
   output logic [OP_W-1:0] b,
   input  logic            eq1,
   input  logic            ae1,
   input  logic            gt1,
   input  logic [3:0]      d1,
   input  logic            eq2,
   input  logic            ae2,
   input  logic            gt2,
   input  logic [3:0]      d2,
   output logic            busy,
   output logic            done,
   output logic [15:0]     vec_cnt,
   output logic [15:0]     err_cnt,
   output logic            err_flag
);

   localparam logic [31:0] LFSR_SEED   = {SEED, ~SEED};
   localparam logic [15:0] N_VEC_W     = 16'(N_VEC);
   localparam logic [3:0]  SETTLE_LAST = 4'(WAIT_CYC - 1);

   mfc_state_t      state, state_d;
   logic [3:0]      settle_cnt;
   logic [31:0]     lfsr_q;
   logic            start_run;
   logic            check_en;
   logic            use_corner;
   logic            lfsr_step;
   logic [OP_W-1:0] op_a, op_b;
   logic [15:0]     vec_cnt_inc;
   mfc_res_t        exp_res, got1, got2;
   logic            vec_fail;

   // The LFSR is reloaded on every start so each run replays the same sequence.
   mfc_lfsr32 #(
      .RST_VAL (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (start_run),
      .step  (lfsr_step),
      .seed  (LFSR_SEED),
      .value (lfsr_q)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   assign vec_cnt_inc = vec_cnt + 16'd1;

   always_comb begin
      state_d   = state;
      busy      = 1'b0;
      done      = 1'b0;
      start_run = 1'b0;
      check_en  = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            done = (state == ST_DONE);
            if (start) begin
               start_run = 1'b1;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            busy    = 1'b1;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            busy = 1'b1;
            if (settle_cnt == SETTLE_LAST) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            busy     = 1'b1;
            check_en = 1'b1;
            state_d  = (vec_cnt_inc == N_VEC_W) ? ST_DONE : ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------- operands
`ifdef MFC_SEQ_CORNER_EN
   assign use_corner = (vec_cnt < 16'd4);
`else
   assign use_corner = 1'b0;
`endif

   // Corner vectors do not consume LFSR states.
   assign lfsr_step = (state == ST_LOAD) && !use_corner;

   always_comb begin
      op_a = lfsr_q[31:16];
      // Every fourth vector is an equal pair so the eq path gets exercised.
      op_b = (vec_cnt[1:0] == 2'b11) ? lfsr_q[31:16] : lfsr_q[15:0];
`ifdef MFC_SEQ_CORNER_EN
      if (use_corner) begin
         op_a = CORNER_TAB[vec_cnt[1:0]][2*OP_W-1:OP_W];
         op_b = CORNER_TAB[vec_cnt[1:0]][OP_W-1:0];
      end
`endif
   end

   // ---------------------------------------------------------- checking
   always_comb begin
      exp_res  = mfc_expect(a, b);
      got1.eq  = eq1;
      got1.ae  = ae1;
      got1.gt  = gt1;
      got1.d   = d1;
      got2.eq  = eq2;
      got2.ae  = ae2;
      got2.gt  = gt2;
      got2.d   = d2;
      vec_fail = (got1 != exp_res) || (got2 != exp_res);
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a          <= '0;
         b          <= '0;
         settle_cnt <= 4'd0;
         vec_cnt    <= 16'd0;
         err_cnt    <= 16'd0;
         err_flag   <= 1'b0;
      end else begin
         // a/b are left alone on start so DONE keeps showing the last vector
         // until the first LOAD of the next run.
         if (start_run) begin
            vec_cnt  <= 16'd0;
            err_cnt  <= 16'd0;
            err_flag <= 1'b0;
         end
         if (state == ST_LOAD) begin
            a          <= op_a;
            b          <= op_b;
            settle_cnt <= 4'd0;
         end
         if (state == ST_SETTLE) begin
            settle_cnt <= settle_cnt + 4'd1;
         end
         if (check_en) begin
            vec_cnt <= vec_cnt_inc;
            if (vec_fail) begin
               err_flag <= 1'b1;
               if (err_cnt != 16'hFFFF) begin
                  err_cnt <= err_cnt + 16'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mfc_vec_seq.sv
// tb/tb_mfc_vec_seq.sv - self-checking bench for mfc_vec_seq with a time-indexed reference model

module tb_mfc_vec_seq;

   localparam int N  = 16;
   localparam int W  = 3;
   localparam int P  = W + 2;
   localparam int FK = 3;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a, b;
   logic        eq1, ae1, gt1, eq2, ae2, gt2;
   logic [3:0]  d1, d2;
   logic        busy, done, err_flag;
   logic [15:0] vec_cnt, err_cnt;

   int checks   = 0;
   int failures = 0;
   int nprint   = 0;
   int fault    = 0;
   bit chk_en   = 0;

   logic [15:0] pa [N];
   logic [15:0] pb [N];

   // model state
   bit          m_run, m_done, m_ef;
   int          m_t;
   logic [15:0] m_vc, m_ec, m_a, m_b;

   mfc_vec_seq #(
      .N_VEC    (N),
      .SEED     (16'hACE1),
      .WAIT_CYC (W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .eq1      (eq1),
      .ae1      (ae1),
      .gt1      (gt1),
      .d1       (d1),
      .eq2      (eq2),
      .ae2      (ae2),
      .gt2      (gt2),
      .d2       (d2),
      .busy     (busy),
      .done     (done),
      .vec_cnt  (vec_cnt),
      .err_cnt  (err_cnt),
      .err_flag (err_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {eq, ae, gt, d}; d = floor(log2(a^b)) or 0
   function automatic logic [6:0] ref_cmp(input logic [15:0] x, input logic [15:0] y);
      logic [16:0] df;
      int          hb;
      df = {1'b0, x ^ y};
      hb = (df == 17'd0) ? 0 : $clog2(df + 17'd1) - 1;
      return {x == y, x >= y, x > y, 4'(hb)};
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   task automatic gen_pairs();
      logic [31:0] l;
      int          first;
      l     = {16'hACE1, ~16'hACE1};
      first = 0;
`ifdef MFC_SEQ_CORNER_EN
      pa[0] = 16'h0000; pb[0] = 16'h0000;
      pa[1] = 16'hFFFF; pb[1] = 16'h0000;
      pa[2] = 16'h8000; pb[2] = 16'h7FFF;
      pa[3] = 16'h53DB; pb[3] = 16'hD3DB;
      first = 4;
`endif
      for (int k = first; k < N; k++) begin
         pa[k] = l[31:16];
         pb[k] = (k % 4 == 3) ? l[31:16] : l[15:0];
         l     = lfsr_next(l);
      end
   endtask

   function automatic bit model_fail(int k);
      if (fault == 1) return pa[k] > pb[k];
      if (fault == 2) return k == FK;
      return 1'b0;
   endfunction

   // comparator environment: correct comparators plus selectable faults on comparator 2
   always_comb begin
      {eq1, ae1, gt1, d1} = ref_cmp(a, b);
      {eq2, ae2, gt2, d2} = ref_cmp(a, b);
      if (fault == 1) gt2 = 1'b0;
      if (fault == 2 && a == pa[FK] && b == pb[FK]) d2 = d2 ^ 4'h1;
   end

   // reference model: run position derived from cycles since start
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run  <= 1'b0; m_done <= 1'b0; m_t <= 0;
         m_vc   <= '0;   m_ec   <= '0;   m_ef <= 1'b0;
         m_a    <= '0;   m_b    <= '0;
      end else if (!m_run && start) begin
         m_run <= 1'b1; m_done <= 1'b0; m_t <= 0;
         m_vc  <= '0;   m_ec   <= '0;   m_ef <= 1'b0;
      end else if (m_run) begin
         if (m_t % P == 0) begin
            m_a <= pa[m_t / P];
            m_b <= pb[m_t / P];
         end
         if (m_t % P == P - 1) begin
            m_vc <= m_vc + 16'd1;
            if (model_fail(m_t / P)) begin
               m_ef <= 1'b1;
               if (m_ec != 16'hFFFF) m_ec <= m_ec + 16'd1;
            end
            if (m_t / P == N - 1) begin
               m_run  <= 1'b0;
               m_done <= 1'b1;
            end
         end
         m_t <= m_t + 1;
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         checks++;
         if (busy !== m_run || done !== m_done || vec_cnt !== m_vc || err_cnt !== m_ec ||
             err_flag !== m_ef || a !== m_a || b !== m_b) begin
            failures++;
            if (nprint < 20) begin
               nprint++;
               $display("FAIL model_cycle t=%0t got busy=%b done=%b vec=%0d err=%0d flag=%b a=%h b=%h exp busy=%b done=%b vec=%0d err=%0d flag=%b a=%h b=%h",
                        $time, busy, done, vec_cnt, err_cnt, err_flag, a, b,
                        m_run, m_done, m_vc, m_ec, m_ef, m_a, m_b);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < N * P + 20) begin
         @(posedge clk);
         #1 cyc++;
      end
      check({name, "_done_seen"}, {63'd0, done}, 64'd1);
   endtask

   int cyc;
   int n_gt;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      fault = 0;
      gen_pairs();

      // model pins against hand-computed values
`ifdef MFC_SEQ_CORNER_EN
      check("pin_pair3_corner", {pa[3], pb[3]}, 64'h53DB_D3DB);
      check("pin_pair4_lfsr",   {pa[4], pb[4]}, 64'hACE1_531E);
      check("pin_pair7_equal",  {pa[7], pb[7]}, 64'h558C_558C);
      check("pin_cmp_corner",   64'(ref_cmp(16'h53DB, 16'hD3DB)), 64'h0F);
`else
      check("pin_pair0", {pa[0], pb[0]}, 64'hACE1_531E);
      check("pin_pair1", {pa[1], pb[1]}, 64'h5670_A98F);
      check("pin_pair2", {pa[2], pb[2]}, 64'hAB18_54C4);
      check("pin_pair3_equal", {pa[3], pb[3]}, 64'h558C_558C);
`endif
      check("pin_cmp_gt", 64'(ref_cmp(16'hACE1, 16'h531E)), 64'h3F);
      check("pin_cmp_eq", 64'(ref_cmp(16'h1234, 16'h1234)), 64'h60);
      check("pin_cmp_lt", 64'(ref_cmp(16'h0010, 16'h0018)), 64'h03);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {a, b, vec_cnt, err_cnt, 13'd0, busy, done, err_flag}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_wait_busy", {63'd0, busy}, 64'd0);

      // run 1: correct comparators
      pulse_start();
      wait_done("run1", cyc);
      check("run1_latency", 64'(cyc), 64'(N * P));
      check("run1_counts", {vec_cnt, err_cnt, 31'd0, err_flag}, {16'(N), 16'd0, 32'd0});

      // run 2: comparator 2 gt stuck at 0
      n_gt = 0;
      for (int k = 0; k < N; k++) if (pa[k] > pb[k]) n_gt++;
      fault = 1;
      pulse_start();
      wait_done("run2", cyc);
      check("run2_err_cnt", 64'(err_cnt), 64'(n_gt));
      check("run2_err_flag", {63'd0, err_flag}, 64'd1);

      // run 3: comparator 2 d off by one on vector FK only
      fault = 2;
      pulse_start();
      wait_done("run3", cyc);
      check("run3_err_cnt", 64'(err_cnt), 64'd1);
      check("run3_err_flag", {63'd0, err_flag}, 64'd1);

      // run 4: reset during SETTLE of vector 5, then a fresh run
      fault = 0;
      pulse_start();
      repeat (5 * P + 1) @(posedge clk);
      @(negedge clk);
      check("pre_abort_vec", {47'd0, busy, vec_cnt}, {47'd1, 16'd5});
      rst_n = 1'b0;
      #1;
      check("abort_outputs", {a, b, vec_cnt, err_cnt, 13'd0, busy, done, err_flag}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_idle", {47'd0, busy, vec_cnt}, 64'd0);
      pulse_start();
      wait_done("run4", cyc);
      check("run4_last_vec", {a, b, vec_cnt}, {pa[N-1], pb[N-1], 16'(N)});
      check("run4_errs", {err_cnt, 15'd0, err_flag}, 32'd0);

      // run 5: start held high across a faulty run; restart on first DONE cycle
      fault = 1;
      @(negedge clk) start = 1'b1;
      wait_done("run5a", cyc);
      check("run5a_vec", 64'(vec_cnt), 64'(N));
      @(posedge clk);
      #1;
      fault = 0;
      check("run5_restart", {busy, done, vec_cnt, err_cnt, err_flag}, {1'b1, 1'b0, 16'd0, 16'd0, 1'b0});
      repeat (2 * P) @(negedge clk);
      start = 1'b0;
      wait_done("run5b", cyc);
      check("run5b_counts", {vec_cnt, err_cnt, 31'd0, err_flag}, {16'(N), 16'd0, 32'd0});

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
